// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers memory-stage results, selects the write-back value,
// qualifies the register-file write, and tracks retired instructions and illegal selects.
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_W,
    input  logic                  flush_W,
    input  logic                  valid_M,
    input  logic                  Reg_Write_M,
    input  logic [1:0]            Result_Src_M,
    input  logic [DATA_W-1:0]     ALU_result_M,
    input  logic [DATA_W-1:0]     mem_read_M,
    input  logic [DATA_W-1:0]     PC_Plus4_M,
    input  logic [REG_ADDR_W-1:0] Rd_M,
    output logic                  valid_W,
    output logic                  Reg_Write_W,
    output logic [REG_ADDR_W-1:0] Rd_W,
    output logic [DATA_W-1:0]     Result_W,
    output logic [CNT_W-1:0]      retire_count_W,
    output logic                  err_W
);

    logic [DATA_W-1:0] result_sel;
    logic              src_illegal;
    logic              write_ok;
    logic              err_hit;
    logic              cnt_full;

    always_comb begin
        result_sel = '0;
        unique case (Result_Src_M)
            2'b00:   result_sel = ALU_result_M;
            2'b01:   result_sel = mem_read_M;
            2'b10:   result_sel = PC_Plus4_M;
            2'b11:   result_sel = '0;
            default: result_sel = '0;
        endcase
    end

    assign src_illegal = (Result_Src_M == 2'b11);
    assign write_ok    = valid_M & Reg_Write_M & (Rd_M != '0) & ~src_illegal;
    assign err_hit     = valid_M & Reg_Write_M & src_illegal;
    assign cnt_full    = &retire_count_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_W        <= 1'b0;
            Reg_Write_W    <= 1'b0;
            Rd_W           <= '0;
            Result_W       <= '0;
            retire_count_W <= '0;
            err_W          <= 1'b0;
        end else if (flush_W) begin
            // Bubble insert; counter and sticky error keep their history
            valid_W     <= 1'b0;
            Reg_Write_W <= 1'b0;
            Rd_W        <= '0;
            Result_W    <= '0;
        end else if (!stall_W) begin
            valid_W     <= valid_M;
            Reg_Write_W <= write_ok;
            Rd_W        <= Rd_M;
            Result_W    <= result_sel;
            if (valid_M && !cnt_full) begin
                retire_count_W <= retire_count_W + 1'b1;
            end
            if (err_hit) begin
                err_W <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a per-cycle reference model.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_W;
    logic          flush_W;
    logic          valid_M;
    logic          Reg_Write_M;
    logic [1:0]    Result_Src_M;
    logic [DW-1:0] ALU_result_M;
    logic [DW-1:0] mem_read_M;
    logic [DW-1:0] PC_Plus4_M;
    logic [AW-1:0] Rd_M;
    logic          valid_W;
    logic          Reg_Write_W;
    logic [AW-1:0] Rd_W;
    logic [DW-1:0] Result_W;
    logic [CW-1:0] retire_count_W;
    logic          err_W;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference state
    bit          m_valid;
    bit          m_rw;
    int unsigned m_rd;
    logic [31:0] m_res;
    int          m_cnt;
    bit          m_err;

    mem_wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_W       (stall_W),
        .flush_W       (flush_W),
        .valid_M       (valid_M),
        .Reg_Write_M   (Reg_Write_M),
        .Result_Src_M  (Result_Src_M),
        .ALU_result_M  (ALU_result_M),
        .mem_read_M    (mem_read_M),
        .PC_Plus4_M    (PC_Plus4_M),
        .Rd_M          (Rd_M),
        .valid_W       (valid_W),
        .Reg_Write_W   (Reg_Write_W),
        .Rd_W          (Rd_W),
        .Result_W      (Result_W),
        .retire_count_W(retire_count_W),
        .err_W         (err_W)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply what the specification says one clock edge does
    task automatic model_edge();
        if (rst) begin
            m_valid = 0; m_rw = 0; m_rd = 0; m_res = 0; m_cnt = 0; m_err = 0;
        end else if (flush_W) begin
            m_valid = 0; m_rw = 0; m_rd = 0; m_res = 0;
        end else if (!stall_W) begin
            m_valid = valid_M;
            m_rd    = Rd_M;
            case (Result_Src_M)
                2'b00:   m_res = ALU_result_M;
                2'b01:   m_res = mem_read_M;
                2'b10:   m_res = PC_Plus4_M;
                default: m_res = 0;
            endcase
            m_rw = valid_M && Reg_Write_M && Rd_M != 0 && Result_Src_M != 2'b11;
            if (valid_M && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (valid_M && Reg_Write_M && Result_Src_M == 2'b11) m_err = 1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_W", 32'(valid_W), 32'(m_valid));
            chk("Reg_Write_W", 32'(Reg_Write_W), 32'(m_rw));
            chk("Rd_W", 32'(Rd_W), m_rd);
            chk("Result_W", Result_W, m_res);
            chk("retire_count_W", 32'(retire_count_W), 32'(m_cnt));
            chk("err_W", 32'(err_W), 32'(m_err));
        end
    end

    task automatic drive(input bit r, input bit st, input bit fl, input bit v,
                         input bit rw, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [4:0] rd);
        rst = r; stall_W = st; flush_W = fl; valid_M = v; Reg_Write_M = rw;
        Result_Src_M = src; ALU_result_M = alu; mem_read_M = mem;
        PC_Plus4_M = pc4; Rd_M = rd;
        @(posedge clk);
        model_edge();
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic instr(input logic [1:0] src, input logic [31:0] alu,
                         input logic [4:0] rd);
        drive(0, 0, 0, 1, 1, src, alu, 32'h22, 32'h33, rd);
    endtask

    initial begin
        @(negedge clk);
        // 1. reset with every input nonzero
        drive(1, 1, 1, 1, 1, 2'b01, 32'hDEAD, 32'hBEEF, 32'hCAFE, 5'd9);
        drive(1, 1, 1, 1, 1, 2'b10, 32'hDEAD, 32'hBEEF, 32'hCAFE, 5'd9);
        chk("rst_result", Result_W, 32'h0);
        chk("rst_valid", 32'(valid_W), 32'h0);
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("idle_count", 32'(retire_count_W), 32'h0);

        // 2. source select
        drive(0, 0, 0, 1, 1, 2'b00, 32'h11, 32'h22, 32'h33, 5'd5);
        chk("sel_alu", Result_W, 32'h11);
        chk("cnt1", 32'(retire_count_W), 32'd1);
        drive(0, 0, 0, 1, 1, 2'b01, 32'h11, 32'h22, 32'h33, 5'd5);
        chk("sel_mem", Result_W, 32'h22);
        drive(0, 0, 0, 1, 1, 2'b10, 32'h11, 32'h22, 32'h33, 5'd5);
        chk("sel_pc4", Result_W, 32'h33);
        chk("sel_rw", 32'(Reg_Write_W), 32'd1);
        chk("sel_rd", 32'(Rd_W), 32'd5);
        chk("cnt3", 32'(retire_count_W), 32'd3);

        // 3. x0 write, then bubble
        instr(2'b00, 32'h44, 5'd0);
        chk("x0_rw", 32'(Reg_Write_W), 32'd0);
        chk("x0_valid", 32'(valid_W), 32'd1);
        chk("x0_cnt", 32'(retire_count_W), 32'd4);
        drive(0, 0, 0, 0, 1, 2'b00, 32'h55, 0, 0, 5'd3);
        chk("bub_rw", 32'(Reg_Write_W), 32'd0);
        chk("bub_cnt", 32'(retire_count_W), 32'd4);

        // 4. stall then flush+stall
        instr(2'b00, 32'hAAAA_0000, 5'd7);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 1, 2'b01, 32'(i), 32'h1234 + 32'(i), 0, 5'(i + 10));
        end
        chk("stall_res", Result_W, 32'hAAAA_0000);
        chk("stall_rd", 32'(Rd_W), 32'd7);
        chk("stall_cnt", 32'(retire_count_W), 32'd5);
        drive(0, 1, 1, 1, 1, 2'b00, 32'h99, 0, 0, 5'd8);
        chk("flush_valid", 32'(valid_W), 32'd0);
        chk("flush_res", Result_W, 32'h0);
        chk("flush_cnt", 32'(retire_count_W), 32'd5);

        // 5. illegal select, sticky error
        drive(0, 0, 0, 1, 0, 2'b11, 32'h77, 0, 0, 5'd4);
        chk("harmless_err", 32'(err_W), 32'd0);
        instr(2'b11, 32'h77, 5'd4);
        chk("ill_res", Result_W, 32'h0);
        chk("ill_rw", 32'(Reg_Write_W), 32'd0);
        chk("ill_err", 32'(err_W), 32'd1);
        for (int i = 0; i < 10; i++) instr(2'(i % 3), 32'(i * 3 + 1), 5'(i + 1));
        chk("err_sticky", 32'(err_W), 32'd1);
        chk("cnt_sat_a", 32'(retire_count_W), 32'd15);
        // reset mid-stall
        drive(1, 1, 0, 1, 1, 2'b00, 32'h1, 0, 0, 5'd1);
        chk("err_clear", 32'(err_W), 32'd0);

        // 6. saturation on 4-bit counter
        for (int i = 0; i < 14; i++) instr(2'b00, 32'(i), 5'd2);
        chk("cnt14", 32'(retire_count_W), 32'd14);
        for (int i = 0; i < 3; i++) begin
            instr(2'b10, 32'(i), 5'd3);
            chk("cnt_hold", 32'(retire_count_W), 32'd15);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline stage that sits directly downstream of the data memory.
- Registers the memory-stage results and selects the write-back value (ALU result, load data or PC+4).
- Presents a qualified register-file write to the register file and to the forwarding logic.
- Supports stall and flush from the hazard unit.
- Keeps a retired-instruction counter and a sticky illegal-select error flag.

Parameters:
DATA_W, 32, width of data/result paths
REG_ADDR_W, 5, register-file address width
CNT_W, 32, retire counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall_W  input  1  hold all W-stage registers this cycle
flush_W  input  1  replace W-stage contents with a bubble this cycle
valid_M  input  1  memory-stage slot holds a real instruction
Reg_Write_M  input  1  instruction writes the register file
Result_Src_M  input  2  write-back select: 00 ALU, 01 load data, 10 PC+4, 11 illegal
ALU_result_M  input  DATA_W  ALU result from memory stage
mem_read_M  input  DATA_W  load data from data memory (combinational, same cycle)
PC_Plus4_M  input  DATA_W  return address for jump-and-link
Rd_M  input  REG_ADDR_W  destination register
valid_W  output  1  W-stage slot holds a real instruction
Reg_Write_W  output  1  qualified register-file write enable
Rd_W  output  REG_ADDR_W  destination register
Result_W  output  DATA_W  selected write-back value
retire_count_W  output  CNT_W  number of instructions captured into W
err_W  output  1  sticky: a valid writing instruction carried Result_Src 11

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
- Reset: on a clk edge with rst=1, all outputs go to 0 (valid_W, Reg_Write_W, Rd_W, Result_W, retire_count_W, err_W). rst has priority over flush_W and stall_W.
- Priority per edge: rst > flush_W > stall_W > capture.
- Flush (flush_W=1):
  - valid_W=0, Reg_Write_W=0, Rd_W=0, Result_W=0.
  - retire_count_W and err_W unchanged.
  - The incoming M-stage instruction is discarded.
- Stall (stall_W=1, flush_W=0): all registers hold, including retire_count_W and err_W.
- Capture (neither asserted), 1-cycle latency from M inputs to W outputs:
  - valid_W <= valid_M.
  - Rd_W <= Rd_M.
  - Result_W <= select(Result_Src_M): 00 ALU_result_M, 01 mem_read_M, 10 PC_Plus4_M, 11 all zeros.
  - Reg_Write_W <= valid_M & Reg_Write_M & (Rd_M != 0) & (Result_Src_M != 11).
- Bubble capture: with valid_M=0, Reg_Write_W is 0 regardless of Reg_Write_M. Result_W and Rd_W still load; consumers must qualify with Reg_Write_W.
- Register x0: a write to Rd=0 is suppressed (Reg_Write_W=0), but valid_W=1 and the instruction counts as retired.
- Retire counter:
  - Increments by 1 on each capture edge with valid_M=1.
  - Saturates at all-ones; it does not wrap.
  - Does not increment on stall, flush or bubble.
- err_W:
  - Set on a capture edge with valid_M=1, Reg_Write_M=1 and Result_Src_M=11.
  - Stays set until rst.
  - Result_Src_M=11 with Reg_Write_M=0 is harmless and does not set err_W.
- Outputs are purely registered; no combinational path from any input to any output.
- Simultaneous flush_W and stall_W: the flush wins and the bubble is inserted.
- rst asserted mid-stall: reset takes effect on that edge. Deasserting rst resumes capture on the next edge.

Test Plan:
1. Reset: rst=1 for 2 cycles with all inputs nonzero -> every output 0. Release rst, all inputs 0 -> outputs stay 0, retire_count_W=0.
2. Source select: valid_M=1, Reg_Write_M=1, Rd_M=5, ALU=0x11, mem=0x22, PC+4=0x33; Result_Src 00/01/10 on three consecutive cycles -> Result_W 0x11, 0x22, 0x33 one cycle later each, Reg_Write_W=1, Rd_W=5, retire_count_W 1, 2, 3.
3. x0 and bubble: Rd_M=0 with Reg_Write_M=1, valid_M=1 -> Reg_Write_W=0, valid_W=1, count +1. Then valid_M=0 with Reg_Write_M=1 -> Reg_Write_W=0, valid_W=0, count unchanged.
4. Stall/flush: capture Result 0xAAAA_0000 to Rd=7, then stall_W=1 for 3 cycles while inputs change -> outputs hold 0xAAAA_0000/7, count frozen. Then flush_W=1 together with stall_W=1 -> valid_W=0, Reg_Write_W=0, Result_W=0, Rd_W=0.
5. Illegal select: valid_M=1, Reg_Write_M=1, Result_Src_M=11 -> Result_W=0, Reg_Write_W=0, err_W=1. err_W stays 1 over 10 further legal instructions and clears only on rst.
6. Saturation: preload the counter at 0xFFFF_FFFE (or use CNT_W=4 at 14), then capture 3 valid instructions -> count reaches 0xFFFF_FFFF (or 15) and holds there.
